main_memory_responder: RTL

//   Responder end of the core's data-memory interface. Serves the core's

---
 rtl/main_memory_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Responder end of the core's data-memory interface. Holds a word-addressed
//   RAM with a combinational read and a clocked write. It also has a 256-word
//   MMIO page containing a cycle counter, a GPIO register, a one-shot
//   down-timer with a sticky expiry flag, and a scratch register.
//
// Ports
//   clk                           clock, all state changes on the rising edge
//   reset                         synchronous, active-low reset
//   address_to_main_memory        word address from the core
//   data_to_main_memory           write data from the core
//   data_to_main_memory_write_en  1 = write this cycle
//   data_from_main_memory         read data, combinational on the address
//   gpio_out                      GPIO register value
//   timer_irq                     sticky timer-expired flag
//   addr_error                    sticky flag, unmapped address presented
//
// MMIO page (word offsets from MMIO_BASE)
//   +0 CYCLE    RO  free-running counter
//   +1 GPIO     RW  drives gpio_out
//   +2 TIMER    RW  write loads the count, read returns the current count
//   +3 TSTAT    RW  bit0 = expired, write 1 to clear
//   +4 SCRATCH  RW  plain storage
module main_memory_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_to_main_memory,
    input  logic [15:0] data_to_main_memory,
    input  logic        data_to_main_memory_write_en,
    output logic [15:0] data_from_main_memory,
    output logic [15:0] gpio_out,
    output logic        timer_irq,
    output logic        addr_error
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] RAM_LIMIT = 17'(DEPTH);

    localparam logic [15:0] OFF_CYCLE   = 16'd0;
    localparam logic [15:0] OFF_GPIO    = 16'd1;
    localparam logic [15:0] OFF_TIMER   = 16'd2;
    localparam logic [15:0] OFF_TSTAT   = 16'd3;
    localparam logic [15:0] OFF_SCRATCH = 16'd4;

    logic [15:0] mem [DEPTH];

    logic [15:0] cycle_count;
    logic [15:0] gpio_q;
    logic [15:0] timer_count;
    logic [15:0] scratch_q;
    logic        expired_q;
    logic        addr_error_q;

    logic          ram_hit;
    logic          mmio_hit;
    logic          unmapped;
    logic [15:0]   mmio_off;
    logic [AW-1:0] ram_idx;

    logic wr_en;
    logic wr_ram;
    logic wr_gpio;
    logic wr_timer;
    logic wr_tstat;
    logic wr_scratch;
    logic timer_fire;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign ram_hit  = {1'b0, address_to_main_memory} < RAM_LIMIT;
    assign mmio_hit = address_to_main_memory >= MMIO_BASE;
    assign unmapped = !ram_hit && !mmio_hit;
    assign mmio_off = address_to_main_memory - MMIO_BASE;
    assign ram_idx  = address_to_main_memory[AW-1:0];

    assign wr_en      = data_to_main_memory_write_en;
    assign wr_ram     = wr_en && ram_hit;
    assign wr_gpio    = wr_en && mmio_hit && (mmio_off == OFF_GPIO);
    assign wr_timer   = wr_en && mmio_hit && (mmio_off == OFF_TIMER);
    assign wr_tstat   = wr_en && mmio_hit && (mmio_off == OFF_TSTAT);
    assign wr_scratch = wr_en && mmio_hit && (mmio_off == OFF_SCRATCH);

    // A load on the same edge as the 1->0 step replaces the countdown, so
    // that step never happens and nothing fires.
    assign timer_fire = !wr_timer && (timer_count == 16'd1);

    // ------------------------------------------------------------------
    // RAM: no reset on the array. The write is held off while reset is low
    // so reset overrides a concurrent write here as it does in MMIO.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && wr_ram) begin
            mem[ram_idx] <= data_to_main_memory;
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers, timer and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count  <= 16'h0000;
            gpio_q       <= 16'h0000;
            timer_count  <= 16'h0000;
            scratch_q    <= 16'h0000;
            expired_q    <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 16'd1;

            if (wr_gpio) begin
                gpio_q <= data_to_main_memory;
            end

            if (wr_scratch) begin
                scratch_q <= data_to_main_memory;
            end

            if (wr_timer) begin
                timer_count <= data_to_main_memory;
            end else if (timer_count != 16'd0) begin
                timer_count <= timer_count - 16'd1;
            end

            // When expiry and a clear land together, setting the flag takes priority.
            if (timer_fire) begin
                expired_q <= 1'b1;
            end else if (wr_tstat && data_to_main_memory[0]) begin
                expired_q <= 1'b0;
            end

            // An idle unmapped address counts as read intent.
            if (unmapped) begin
                addr_error_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux: reflects current state, ahead of any write on this edge
    // ------------------------------------------------------------------
    always_comb begin
        data_from_main_memory = 16'h0000;
        if (ram_hit) begin
            data_from_main_memory = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                OFF_CYCLE:   data_from_main_memory = cycle_count;
                OFF_GPIO:    data_from_main_memory = gpio_q;
                OFF_TIMER:   data_from_main_memory = timer_count;
                OFF_TSTAT:   data_from_main_memory = {15'h0000, expired_q};
                OFF_SCRATCH: data_from_main_memory = scratch_q;
                default:     data_from_main_memory = 16'h0000;
            endcase
        end
    end

    assign gpio_out   = gpio_q;
    assign timer_irq  = expired_q;
    assign addr_error = addr_error_q;

endmodule
